sd_cmd_sequencer: RTL
=====================

Name: sd_cmd_sequencer

Overview:
- Hardware SD-card command sequencer in SPI mode, layered on the byte-level SPI shift engine.
- Each command is started by one CMD_START pulse; the block handles the rest:
  - chip select;
  - leading dummy bytes;
  - 6-byte command frame with CRC;
  - R1 response polling;
  - trailing Nec byte.
- Replaces the 68k byte-by-byte "read-to-write" command issuing, so software only supplies index and argument and reads back R1.
- Owns the SPI engine only while CMD_BUSY is 1.

Parameters:
- PRE_DUMMY, 1: number of 0xFF bytes sent after CS falls and before the frame (0..3).
- RESP_POLL_MAX, 8: maximum number of 0xFF bytes clocked while waiting for R1 (Ncr limit, 1..255).

Ports:
- CLOCK_50 in 1: system clock.
- nRESET in 1: synchronous, active-low reset.
- CMD_START in 1: one-cycle start pulse; ignored while CMD_BUSY=1.
- CMD_INDEX in 6: command index, latched at start.
- CMD_ARG in 32: argument, latched at start.
- CMD_HOLD_CS in 1: latched at start; 1 = keep CS low after completion (data phase follows).
- ABORT in 1: one-cycle abort request.
- CMD_BUSY out 1: 1 from the cycle after an accepted start until the cycle CMD_DONE pulses.
- CMD_DONE out 1: one-cycle completion pulse.
- CMD_R1 out 8: last R1 received; 0xFF on timeout or abort.
- CMD_TIMEOUT out 1: valid with CMD_DONE, held until next start.
- CMD_ABORTED out 1: valid with CMD_DONE, held until next start.
- SPI_TX out 8: byte to transmit.
- SPI_START out 1: one-cycle request to the engine to shift SPI_TX.
- SPI_DONE in 1: one-cycle pulse from the engine; SPI_RX is valid in the same cycle.
- SPI_RX in 8: received byte.
- SPI_CS_N out 1: SD chip select, active low.

Behaviour:
- Reset values:
  - CMD_BUSY=0, CMD_DONE=0, CMD_R1=0xFF, CMD_TIMEOUT=0, CMD_ABORTED=0;
  - SPI_TX=0xFF, SPI_START=0, SPI_CS_N=1;
  - state IDLE, hold flag 0.
- A reset in mid-operation takes effect immediately and abandons any in-flight byte; SPI_DONE arriving in IDLE is ignored.
- Byte transfer, used by every state:
  - ISSUE cycle: drive SPI_TX and pulse SPI_START=1 for exactly one cycle.
  - Then WAIT until SPI_DONE=1.
  - Only one byte is ever outstanding.
- States:
  - IDLE:
    - On CMD_START, latch index/arg/hold; clear TIMEOUT and ABORTED.
    - SPI_CS_N<=0 and CMD_BUSY<=1 in the next cycle.
    - Go to PRE, or to FRAME if PRE_DUMMY=0.
  - PRE: send PRE_DUMMY bytes of 0xFF, then go to FRAME.
  - FRAME: send 6 bytes, byte counter 0..5:
    - byte 0: {2'b01, CMD_INDEX};
    - bytes 1..4: ARG[31:24], [23:16], [15:8], [7:0];
    - byte 5: {CRC7, 1'b1}.
    - Then go to POLL.
  - POLL:
    - Send 0xFF and examine SPI_RX at SPI_DONE.
    - If bit7=0, CMD_R1<=SPI_RX and go to POST.
    - Otherwise increment the poll counter; when the count reaches RESP_POLL_MAX, set CMD_TIMEOUT=1, CMD_R1=0xFF, and go to POST.
  - POST:
    - Send one 0xFF byte (Nec).
    - At its SPI_DONE: SPI_CS_N<=~hold, CMD_DONE=1 for one cycle, CMD_BUSY<=0, go to IDLE.
- CRC7:
  - Polynomial x^7+x^3+1, register initialised to 0.
  - Updated MSB-first over the 40 bits of bytes 0..4.
  - Computed serially (one bit per cycle during PRE/FRAME byte waits) or in parallel; the value must be ready before the byte-5 ISSUE cycle.
- Hold:
  - With hold=1, SPI_CS_N stays 0 in IDLE.
  - A following start keeps it 0 with no glitch.
  - A start with CMD_HOLD_CS=0 releases CS at its completion.
- ABORT:
  - In IDLE: forces SPI_CS_N=1 and hold=0; no CMD_DONE pulse.
  - While busy: latched. The in-flight byte is completed (SPI_DONE awaited) and no further byte is issued. Then SPI_CS_N=1, hold cleared, CMD_R1=0xFF, CMD_ABORTED=1, CMD_DONE pulses.
  - ABORT takes priority over a valid R1 arriving in the same SPI_DONE cycle.
- CMD_START coincident with ABORT in IDLE: ABORT wins and the start is dropped.
- Latency from an accepted start to the first SPI_START: 2 cycles (CS-setup cycle, then ISSUE).

Optional Feature:
- Macro SD_CMD_CRC7_EN.
- Defined: the CRC7 generator is built as described above.
- Undefined: no generator. Byte 5 is fixed:
  - 0x95 when CMD_INDEX=0;
  - 0x87 when CMD_INDEX=8;
  - 0x01 otherwise (card CRC checking off).
- All other behaviour is identical.

Test Plan:
- CMD0, arg 0, PRE_DUMMY=1, engine model replies 0xFF,0xFF,0x01 in POLL -> TX sequence FF,40,00,00,00,00,95,FF,FF,FF,FF. Check CMD_R1=0x01, TIMEOUT=0, single CMD_DONE, SPI_CS_N high after the last SPI_DONE.
- CMD8, arg 0x000001AA, with SD_CMD_CRC7_EN defined and undefined -> frame 48,00,00,01,AA,87 in both builds.
- Engine always returns 0xFF, RESP_POLL_MAX=8 -> exactly 8 POLL bytes plus 1 POST byte. Check CMD_TIMEOUT=1, CMD_R1=0xFF.
- CMD17 with hold=1, R1=0x00, then back-to-back CMD_START with hold=0 -> SPI_CS_N stays 0 across both commands and rises after the second CMD_DONE. A CMD_START pulsed during the first command is ignored.
- ABORT asserted mid-FRAME byte 2 -> byte 2 completes, no byte 3 is issued. Check CMD_ABORTED=1, CMD_R1=0xFF, SPI_CS_N=1.
- nRESET asserted during POLL -> next cycle all outputs at reset values; a stray SPI_DONE afterwards is ignored.

Source files
------------

// File: rtl/sd_cmd_sequencer.sv
// sd_cmd_sequencer
//   SD-card command sequencer for SPI mode, sitting on top of a byte-level
//   SPI shift engine. One CMD_START pulse runs a whole command: chip select,
//   leading 0xFF dummy bytes, the 6-byte command frame, R1 polling and the
//   trailing Nec byte. The engine is driven only while CMD_BUSY is 1.
//
//   Parameters
//     PRE_DUMMY      0xFF bytes sent between CS falling and the frame (0..3)
//     RESP_POLL_MAX  maximum 0xFF bytes clocked while waiting for R1 (1..255)
//
//   Build option
//     SD_CMD_CRC7_EN  defined: byte 5 carries a CRC7 computed over bytes 0..4.
//                     undefined: byte 5 is 0x95 (CMD0), 0x87 (CMD8), else 0x01.
//
//   Ports
//     CLOCK_50, nRESET          clock, synchronous active-low reset
//     CMD_START                 one-cycle start pulse (ignored while busy)
//     CMD_INDEX, CMD_ARG        command index / argument, latched at start
//     CMD_HOLD_CS               latched at start; 1 keeps CS low after completion
//     ABORT                     one-cycle abort request
//     CMD_BUSY, CMD_DONE        busy level, one-cycle completion pulse
//     CMD_R1                    last R1 (0xFF on timeout/abort)
//     CMD_TIMEOUT, CMD_ABORTED  completion status, held until next start
//     SPI_TX, SPI_START         byte and one-cycle shift request to the engine
//     SPI_DONE, SPI_RX          engine completion pulse and received byte
//     SPI_CS_N                  card chip select, active low
module sd_cmd_sequencer #(
  parameter int PRE_DUMMY     = 1,
  parameter int RESP_POLL_MAX = 8
) (
  input  logic        CLOCK_50,
  input  logic        nRESET,
  input  logic        CMD_START,
  input  logic [5:0]  CMD_INDEX,
  input  logic [31:0] CMD_ARG,
  input  logic        CMD_HOLD_CS,
  input  logic        ABORT,
  output logic        CMD_BUSY,
  output logic        CMD_DONE,
  output logic [7:0]  CMD_R1,
  output logic        CMD_TIMEOUT,
  output logic        CMD_ABORTED,
  output logic [7:0]  SPI_TX,
  output logic        SPI_START,
  input  logic        SPI_DONE,
  input  logic [7:0]  SPI_RX,
  output logic        SPI_CS_N
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PRE, S_FRAME, S_POLL, S_POST
  } state_t;

  localparam logic [2:0] PRE_LAST  = (PRE_DUMMY > 0) ? 3'(PRE_DUMMY - 1) : 3'd0;
  localparam logic [7:0] POLL_LAST = 8'(RESP_POLL_MAX);

`ifdef SD_CMD_CRC7_EN
  // CRC7, polynomial x^7+x^3+1, zero initial value, MSB first.
  function automatic logic [6:0] crc7(input logic [39:0] bits);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = bits[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction
`endif

  state_t      state_q, state_nx;
  logic        wait_q, wait_nx;          // 0: ISSUE cycle, 1: waiting for SPI_DONE
  logic [2:0]  cnt_q, cnt_nx;
  logic [7:0]  poll_q, poll_nx;
  logic        hold_q, hold_nx;
  logic        abort_q, abort_nx;
  logic        busy_q, busy_nx;
  logic        done_q, done_nx;
  logic [7:0]  r1_q, r1_nx;
  logic        to_q, to_nx;
  logic        ab_q, ab_nx;
  logic        csn_q, csn_nx;
  logic [5:0]  idx_q;
  logic [31:0] arg_q;
  logic [7:0]  crc_byte;
  logic [7:0]  tx_c;
  logic        start_c;
  logic        finish_abort;
  logic        start_acc;

  // ABORT wins over a coincident start in IDLE.
  assign start_acc = (state_q == S_IDLE) && CMD_START && !ABORT;

`ifdef SD_CMD_CRC7_EN
  assign crc_byte = {crc7({2'b01, idx_q, arg_q}), 1'b1};
`else
  always_comb begin
    case (idx_q)
      6'd0:    crc_byte = 8'h95;
      6'd8:    crc_byte = 8'h87;
      default: crc_byte = 8'h01;
    endcase
  end
`endif

  always_ff @(posedge CLOCK_50) begin
    if (start_acc) begin
      idx_q <= CMD_INDEX;
      arg_q <= CMD_ARG;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!nRESET) begin
      state_q <= S_IDLE;
      wait_q  <= 1'b0;
      cnt_q   <= '0;
      poll_q  <= '0;
      hold_q  <= 1'b0;
      abort_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      r1_q    <= 8'hFF;
      to_q    <= 1'b0;
      ab_q    <= 1'b0;
      csn_q   <= 1'b1;
    end else begin
      state_q <= state_nx;
      wait_q  <= wait_nx;
      cnt_q   <= cnt_nx;
      poll_q  <= poll_nx;
      hold_q  <= hold_nx;
      abort_q <= abort_nx;
      busy_q  <= busy_nx;
      done_q  <= done_nx;
      r1_q    <= r1_nx;
      to_q    <= to_nx;
      ab_q    <= ab_nx;
      csn_q   <= csn_nx;
    end
  end

  always_comb begin
    state_nx     = state_q;
    wait_nx      = wait_q;
    cnt_nx       = cnt_q;
    poll_nx      = poll_q;
    hold_nx      = hold_q;
    abort_nx     = abort_q;
    busy_nx      = busy_q;
    done_nx      = 1'b0;
    r1_nx        = r1_q;
    to_nx        = to_q;
    ab_nx        = ab_q;
    csn_nx       = csn_q;
    finish_abort = 1'b0;
    tx_c         = 8'hFF;
    start_c      = 1'b0;

    if ((state_q inside {S_PRE, S_FRAME, S_POLL, S_POST}) && !wait_q) start_c = 1'b1;

    if (state_q == S_FRAME) begin
      case (cnt_q)
        3'd0:    tx_c = {2'b01, idx_q};
        3'd1:    tx_c = arg_q[31:24];
        3'd2:    tx_c = arg_q[23:16];
        3'd3:    tx_c = arg_q[15:8];
        3'd4:    tx_c = arg_q[7:0];
        3'd5:    tx_c = crc_byte;
        default: tx_c = 8'hFF;
      endcase
    end

    // Abort while busy is only acted on once no byte is outstanding.
    if (state_q != S_IDLE && ABORT) abort_nx = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (ABORT) begin
          csn_nx  = 1'b1;
          hold_nx = 1'b0;
        end else if (CMD_START) begin
          hold_nx  = CMD_HOLD_CS;
          to_nx    = 1'b0;
          ab_nx    = 1'b0;
          csn_nx   = 1'b0;
          busy_nx  = 1'b1;
          abort_nx = 1'b0;
          cnt_nx   = '0;
          poll_nx  = '0;
          wait_nx  = 1'b0;
          state_nx = S_SETUP;
        end
      end
      // CS-setup cycle: CS is already low, the first byte issues next.
      S_SETUP: begin
        if (abort_q || ABORT) finish_abort = 1'b1;
        else                  state_nx = (PRE_DUMMY == 0) ? S_FRAME : S_PRE;
      end
      default: begin
        if (!wait_q) begin
          wait_nx = 1'b1;
        end else if (SPI_DONE) begin
          wait_nx = 1'b0;
          if (abort_q || ABORT) begin
            finish_abort = 1'b1;
          end else begin
            case (state_q)
              S_PRE: begin
                if (cnt_q == PRE_LAST) begin
                  cnt_nx   = '0;
                  state_nx = S_FRAME;
                end else begin
                  cnt_nx = cnt_q + 3'd1;
                end
              end
              S_FRAME: begin
                if (cnt_q == 3'd5) begin
                  cnt_nx   = '0;
                  state_nx = S_POLL;
                end else begin
                  cnt_nx = cnt_q + 3'd1;
                end
              end
              S_POLL: begin
                if (!SPI_RX[7]) begin
                  r1_nx    = SPI_RX;
                  state_nx = S_POST;
                end else if (poll_q + 8'd1 == POLL_LAST) begin
                  to_nx    = 1'b1;
                  r1_nx    = 8'hFF;
                  state_nx = S_POST;
                end else begin
                  poll_nx = poll_q + 8'd1;
                end
              end
              S_POST: begin
                csn_nx   = ~hold_q;
                done_nx  = 1'b1;
                busy_nx  = 1'b0;
                state_nx = S_IDLE;
              end
              default: state_nx = S_IDLE;
            endcase
          end
        end
      end
    endcase

    if (finish_abort) begin
      state_nx = S_IDLE;
      wait_nx  = 1'b0;
      csn_nx   = 1'b1;
      hold_nx  = 1'b0;
      r1_nx    = 8'hFF;
      ab_nx    = 1'b1;
      done_nx  = 1'b1;
      busy_nx  = 1'b0;
      abort_nx = 1'b0;
    end
  end

  assign CMD_BUSY    = busy_q;
  assign CMD_DONE    = done_q;
  assign CMD_R1      = r1_q;
  assign CMD_TIMEOUT = to_q;
  assign CMD_ABORTED = ab_q;
  assign SPI_TX      = tx_c;
  assign SPI_START   = start_c;
  assign SPI_CS_N    = csn_q;

endmodule
